// File: rtl/apb_master_bridge.sv
// APB4 initiator: converts single-outstanding core load/store requests into
// SETUP/ACCESS transfers, with registered completion and a PREADY watchdog.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int STRB_W  = DATA_W / 8,
  parameter int TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_strb,
  output logic              o_ready,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  output logic [STRB_W-1:0] PSTRB,
  output logic              PSEL,
  output logic              PENABLE,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                ready_q, ready_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                timeout_hit;

  // Abort fires on the edge that would bring the wait count up to TIMEOUT,
  // so the slave sees exactly TIMEOUT ACCESS cycles; PREADY on that edge wins.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    ready_d   = ready_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;

    case (state_q)
      IDLE: begin
        if (i_req) begin
          state_d  = SETUP;
          cnt_d    = '0;
          paddr_d  = i_addr;
          pwrite_d = i_we;
          pwdata_d = i_wdata;
          pstrb_d  = i_we ? i_strb : '0;
          psel_d   = 1'b1;
          ready_d  = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY || timeout_hit) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          ack_d     = 1'b1;
          err_d     = PREADY ? PSLVERR : 1'b1;
          rdata_d   = (PREADY && !pwrite_q) ? PRDATA : '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        ready_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      ready_q   <= 1'b1;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      ready_q   <= ready_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign o_ready = ready_q;
  assign o_ack   = ack_q;
  assign o_err   = err_q;
  assign o_rdata = rdata_q;
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign PSTRB   = pstrb_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized
// transfers checked against a per-transfer cycle timeline model.
module tb_apb_master_bridge;

  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic        i_req = 1'b0;
  logic        i_we = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [3:0]  i_strb = '0;
  logic        o_ready, o_ack, o_err;
  logic [31:0] o_rdata;
  logic [31:0] PADDR, PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int checks = 0;
  int fails = 0;

  apb_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .STRB_W(4), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_strb(i_strb),
    .o_ready(o_ready), .o_ack(o_ack), .o_rdata(o_rdata), .o_err(o_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // One complete transfer. The expected timeline: cycle 1 is SETUP, cycles
  // 2..acc+1 are ACCESS, cycle acc+2 carries the ack back in idle.
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input int nwait, input logic slverr, input logic [31:0] prdata,
                      input logic hang, input logic hold_req);
    logic        aborted;
    int          acc;
    logic [3:0]  exp_ctl, got_ctl;
    logic [68:0] exp_apb, got_apb;
    logic [31:0] exp_rd;
    logic        exp_err;
    aborted = hang || (nwait >= TO);
    acc     = aborted ? TO : nwait + 1;
    exp_apb = {addr, we, wdata, (we ? strb : 4'h0)};
    exp_rd  = (aborted || we) ? 32'h0 : prdata;
    exp_err = aborted ? 1'b1 : slverr;
    i_req = 1'b1; i_we = we; i_addr = addr; i_wdata = wdata; i_strb = strb;
    PREADY = 1'b0;
    for (int k = 1; k <= acc + 2; k++) begin
      @(posedge PCLK); #1;
      if (k == 1) begin
        if (hold_req) begin
          i_addr = $urandom; i_wdata = $urandom;
          i_we = 1'($urandom); i_strb = 4'($urandom);
        end else begin
          i_req = 1'b0;
        end
      end
      exp_ctl = {(k <= acc + 1), (k >= 2 && k <= acc + 1), (k == acc + 2), (k == acc + 2)};
      got_ctl = {PSEL, PENABLE, o_ack, o_ready};
      checks++;
      if (got_ctl !== exp_ctl) begin
        fails++;
        $display("[TB] FAIL %s ctl cycle %0d: got %b expected %b (psel,penable,ack,ready)",
                 tag, k, got_ctl, exp_ctl);
      end
      if (k <= acc + 1) begin
        got_apb = {PADDR, PWRITE, PWDATA, PSTRB};
        checks++;
        if (got_apb !== exp_apb) begin
          fails++;
          $display("[TB] FAIL %s apb cycle %0d: got %h expected %h (addr,write,wdata,strb)",
                   tag, k, got_apb, exp_apb);
        end
      end
      if (k == acc + 2) begin
        checks++;
        if (o_rdata !== exp_rd) begin
          fails++;
          $display("[TB] FAIL %s rdata: got %h expected %h", tag, o_rdata, exp_rd);
        end
        checks++;
        if (o_err !== exp_err) begin
          fails++;
          $display("[TB] FAIL %s err: got %b expected %b", tag, o_err, exp_err);
        end
      end
      PREADY  = (k >= 2) && !hang && ((k - 1) == nwait + 1);
      PSLVERR = PREADY ? slverr : 1'b1;
      PRDATA  = PREADY ? prdata : $urandom;
    end
    PREADY = 1'b0;
    PSLVERR = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    i_req = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge PCLK); #1;
      checks++;
      if ({PSEL, PENABLE, o_ack, o_ready} !== 4'b0001) begin
        fails++;
        $display("[TB] FAIL idle ctl: got %b expected 0001", {PSEL, PENABLE, o_ack, o_ready});
      end
    end
  endtask

  task automatic test_reset();
    #1 PRESETn = 1'b0;
    #2;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, o_ack, o_err, o_rdata} !== '0) begin
      fails++;
      $display("[TB] FAIL reset outputs: got %h expected 0",
               {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, o_ack, o_err, o_rdata});
    end
    checks++;
    if (o_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset ready: got %b expected 1", o_ready);
    end
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_zero_wait_write();
    xfer("zero_wait_write", 1'b1, 32'h4000_0004, 32'hA5A5_0055, 4'hF, 0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_wait_read();
    xfer("wait_read", 1'b0, 32'h4000_0008, 32'h1234_5678, 4'hF, 3, 1'b0, 32'h0000_00C3, 1'b0, 1'b0);
  endtask

  task automatic test_slverr();
    xfer("slverr_now", 1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'h3, 0, 1'b1, 32'h0, 1'b0, 1'b0);
    xfer("slverr_in_wait", 1'b1, 32'h4000_0014, 32'hCAFE_F00D, 4'hC, 2, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    xfer("timeout_abort", 1'b1, 32'h4000_0020, 32'h0BAD_0BAD, 4'hF, 0, 1'b0, 32'h0, 1'b1, 1'b0);
    xfer("after_timeout", 1'b0, 32'h4000_0024, 32'h0, 4'h0, 1, 1'b0, 32'h5555_AAAA, 1'b0, 1'b0);
  endtask

  task automatic test_ready_at_timeout();
    xfer("ready_at_limit", 1'b0, 32'h4000_0030, 32'h0, 4'h0, TO - 1, 1'b0, 32'h7777_1111, 1'b0, 1'b0);
    xfer("err_at_limit", 1'b1, 32'h4000_0034, 32'h1, 4'h1, TO - 1, 1'b1, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    xfer("b2b_first", 1'b0, 32'h4000_0040, 32'h0, 4'h0, 1, 1'b0, 32'h0102_0304, 1'b0, 1'b1);
    xfer("b2b_second", 1'b0, 32'h4000_0044, 32'h0, 4'h0, 0, 1'b0, 32'h0506_0708, 1'b0, 1'b0);
    idle_cycles(1);
  endtask

  task automatic test_reset_mid_access();
    i_req = 1'b1; i_we = 1'b1; i_addr = 32'h4000_0050; i_wdata = 32'hFFFF_0000; i_strb = 4'hF;
    PREADY = 1'b0;
    @(posedge PCLK); #1;
    i_req = 1'b0;
    @(posedge PCLK); #1;
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      fails++;
      $display("[TB] FAIL pre_reset access: got %b expected 11", {PSEL, PENABLE});
    end
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, o_ack, o_err, o_rdata} !== '0) begin
      fails++;
      $display("[TB] FAIL mid_reset outputs: got %h expected 0",
               {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, o_ack, o_err, o_rdata});
    end
    checks++;
    if (o_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_reset ready: got %b expected 1", o_ready);
    end
    PREADY = 1'b1;
    @(posedge PCLK); #1;
    PREADY = 1'b0;
    PRESETn = 1'b1;
    idle_cycles(3);
  endtask

  task automatic test_random();
    logic        we, slverr, hang, hold;
    logic [31:0] addr, wdata, prdata;
    logic [3:0]  strb;
    int          nwait;
    for (int i = 0; i < 30; i++) begin
      we     = 1'($urandom);
      addr   = $urandom;
      wdata  = $urandom;
      strb   = 4'($urandom);
      nwait  = int'($urandom_range(0, TO + 1));
      slverr = 1'($urandom);
      prdata = $urandom;
      hang   = ($urandom_range(0, 5) == 0);
      hold   = (i < 29) && ($urandom_range(0, 1) == 1);
      xfer("random", we, addr, wdata, strb, nwait, slverr, prdata, hang, hold);
      if (!hold && $urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_ready_at_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_zero_wait_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
